muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide responder for the pipelined MIPS core. Accepts the
//  Execute-stage muldiv request (muldivE) and produces the HI/LO result after a
//  fixed multi-cycle latency. Supplies HI/LO to the Memory-stage mfhi/mflo reads.
//  Raises a stall while busy so the hazard unit can hold the pipeline.
// PARAMETERS
//  WIDTH  32  Operand width; HI and LO are WIDTH bits each; iteration count = WIDTH.
// PORTS
//  clk      in   1      Clock; all state updates on its rising edge.
//  reset    in   1      Synchronous reset, active-high.
//  startE   in   1      Request, driven from muldivE; sampled only in IDLE.
//  opE      in   2      Operation: 00 mult, 01 multu, 10 div, 11 divu.
//  srcaE    in   WIDTH  Multiplicand / dividend (rs).
//  srcbE    in   WIDTH  Multiplier / divisor (rt).
//  flushE   in   1      Abort the in-flight operation; HI/LO unchanged.
//  mfreqM   in   1      mfhiM | mfloM; a HI/LO read is pending in Memory.
//  busy     out  1      High while an operation is iterating.
//  stall    out  1      busy & (startE | mfreqM); combinational.
//  done     out  1      One-cycle pulse after HI/LO are written.
//  hi       out  WIDTH  HI register; remainder, or upper product half.
//  lo       out  WIDTH  LO register; quotient, or lower product half.
// BEHAVIOUR
//  Reset: state=IDLE, count=0, busy=0, done=0, hi=0, lo=0. Reset overrides all inputs,
//   including an operation that is mid-flight.
//  FSM states: IDLE, RUN.
//   IDLE -> RUN on an edge where startE=1 and flushE=0 (edge E0).
//    Latch operand magnitudes and sign flags; count=0.
//   RUN: each edge performs one iteration and sets count=count+1.
//    mul: shift-add, one multiplier bit per edge.
//    div: restoring shift-subtract, one quotient bit per edge.
//   RUN -> IDLE at edge E(WIDTH), after the last iteration. The same edge writes hi/lo.
//    done=1 for exactly one cycle after that edge.
//   RUN -> IDLE on any edge with flushE=1. Partial result discarded; hi, lo and done
//    untouched.
//  Timing: busy=1 for exactly WIDTH cycles, from after E0 through E(WIDTH).
//   Result is readable in the cycle after E(WIDTH).
//  startE while busy: ignored, not queued. The pipeline is held via stall, and the
//   request is re-presented and accepted in the cycle after busy falls.
//  startE and flushE together in IDLE: request not accepted.
//  Arithmetic:
//   Signed ops use magnitudes, then fix the result sign.
//   mult: {hi,lo} = full 2*WIDTH two's-complement product.
//   multu: unsigned product.
//   div: lo = quotient truncated toward zero; hi takes the sign of the dividend.
//   divu: unsigned quotient and remainder.
//   Overflow: div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps).
//   Divide by zero (div or divu): lo=all ones, hi=srcaE. Still takes WIDTH cycles;
//    never hangs.
//  hi/lo are stable outside the completion edge. mfhi/mflo in the done cycle see the
//   new values.
// TESTING
//  mult 7 x 0xFFFFFFFD (-3) -> busy for 32 cycles, then hi=FFFFFFFF, lo=FFFFFFEB,
//   done pulses once.
//  multu FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; mult on the same operands
//   -> hi=0, lo=1.
//  div FFFFFFF9 (-7) / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 7/2 -> lo=3, hi=1.
//  divu 5/0 -> lo=FFFFFFFF, hi=5; div 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  Interrupt and stall cases, with prior hi=lo=0x1234:
//   flushE at cycle 10 of a div -> busy=0 next cycle, done never pulses, hi/lo still
//    0x1234.
//   reset at cycle 20 -> all outputs 0.
//   mfreqM while busy -> stall=1.
//   startE at cycle 5 of RUN -> ignored, and the result matches the first operation.

Source files
------------

// File: rtl/muldiv_if.sv
// Execute/Memory-side handshake for the iterative multiply/divide unit.
// The master drives requests and HI/LO reads; the slave returns status and HI/LO.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             flushE;
    logic             mfreqM;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, opE, srcaE, srcbE, flushE, mfreqM,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, flushE, mfreqM,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock, WIDTH steps per operation, with sign fix-up on the final edge.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   md
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH:0]     acc_q;      // upper product half, or partial remainder
    logic [WIDTH-1:0]   q_q;        // multiplier bits, or dividend/quotient bits
    logic [WIDTH-1:0]   b_q;        // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               neg_q_q;    // negate product / quotient at the end
    logic               neg_r_q;    // negate remainder at the end
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_d;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               last;

    // Operand magnitudes and sign flags for the request being presented
    always_comb begin
        sa    = ~md.opE[0] & md.srcaE[WIDTH-1];
        sb    = ~md.opE[0] & md.srcbE[WIDTH-1];
        mag_a = sa ? -md.srcaE : md.srcaE;
        mag_b = sb ? -md.srcbE : md.srcbE;
    end

    always_comb begin
        mul_sum  = acc_q + (q_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_diff = {1'b0, div_sh} - {2'b00, b_q};
        if (is_div_q) begin
            // A zero divisor never borrows, so the quotient fills with ones
            // and the remainder collects the whole dividend.
            if (!div_diff[WIDTH+1]) begin
                acc_d = div_diff[WIDTH:0];
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_sh;
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        prod     = {acc_d[WIDTH-1:0], q_d};
        prod_fix = neg_q_q ? -prod : prod;
        quot_fix = neg_q_q ? -q_d : q_d;
        rem_fix  = neg_r_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
        hi_d     = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
        last     = (count_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md.startE && !md.flushE) begin
                        state_q  <= RUN;
                        count_q  <= '0;
                        acc_q    <= '0;
                        q_q      <= mag_a;
                        b_q      <= mag_b;
                        is_div_q <= md.opE[1];
                        // Divide by zero keeps the raw all-ones quotient
                        neg_q_q  <= (sa ^ sb) & (~md.opE[1] | (|md.srcbE));
                        neg_r_q  <= sa;
                    end
                end
                RUN: begin
                    if (md.flushE) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        q_q     <= q_d;
                        count_q <= count_q + 1'b1;
                        if (last) begin
                            state_q <= IDLE;
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.busy  = (state_q == RUN);
    assign md.stall = md.busy & (md.startE | md.mfreqM);
    assign md.done  = done_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
endmodule
